ptp_perout_sched: RTL and testbench

PTP_PEROUT_SCHED -- requirements
Module: ptp_perout_sched

---
 rtl/ptp_perout_sched.sv | 127 ++++++++++++
 tb/tb_ptp_perout_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ptp_perout_sched.sv
// ptp_perout_sched: PTP periodic output scheduler driven by a 96-bit time of day
// Ports:
//   clk, rst                      - single clock, asynchronous active-high reset
//   input_ts_tod                  - current ToD {s[47:0], ns[31:0], fns[15:0]}
//   input_ts_tod_step             - one-cycle pulse flagging a ToD discontinuity
//   enable                        - output enable level
//   input_start/period/width(+_valid) - schedule shadow loads
//   locked                        - high once a full pulse has completed on schedule
//   error                         - high while width >= period or period == 0
//   output_pulse                  - registered periodic output
module ptp_perout_sched #(
  parameter logic [47:0] OUT_START_S   = 48'h0,
  parameter logic [31:0] OUT_START_NS  = 32'd0,
  parameter logic [47:0] OUT_PERIOD_S  = 48'd1,
  parameter logic [31:0] OUT_PERIOD_NS = 32'd0,
  parameter logic [31:0] OUT_WIDTH_NS  = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] input_ts_tod,
  input  logic        input_ts_tod_step,
  input  logic        enable,
  input  logic [95:0] input_start,
  input  logic        input_start_valid,
  input  logic [95:0] input_period,
  input  logic        input_period_valid,
  input  logic [95:0] input_width,
  input  logic        input_width_valid,
  output logic        locked,
  output logic        error,
  output logic        output_pulse
);
  localparam logic [32:0] NS_PER_S     = 33'd1_000_000_000;
  localparam logic [95:0] START_INIT  = {OUT_START_S, OUT_START_NS, 16'h0};
  localparam logic [95:0] PERIOD_INIT = {OUT_PERIOD_S, OUT_PERIOD_NS, 16'h0};
  localparam logic [95:0] WIDTH_INIT  = {48'h0, OUT_WIDTH_NS, 16'h0};
  typedef enum logic [2:0] {IDLE, CATCHUP, ARMED, HIGH, ADD} state_t;
  function automatic logic [95:0] tod_add(input logic [95:0] a, input logic [95:0] b);
    logic [16:0] f;
    logic [32:0] n;
    logic c;
    f = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    n = {1'b0, a[47:16]} + {1'b0, b[47:16]} + {32'd0, f[16]};
    c = n >= NS_PER_S;
    n = c ? n - NS_PER_S : n;
    return {a[95:48] + b[95:48] + {47'd0, c}, n[31:0], f[15:0]};
  endfunction
  state_t state_q, state_d;
  logic [95:0] start_q, start_d, period_q, period_d, width_q, width_d;
  logic [95:0] next_rise_q, next_rise_d, next_fall_q, next_fall_d, rise_inc;
  logic pulse_q, pulse_d, locked_q, locked_d, error_q, error_d, force_idle;
  always_comb begin
    start_d     = input_start_valid ? input_start : start_q;
    period_d    = input_period_valid ? input_period : period_q;
    width_d     = input_width_valid ? input_width : width_q;
    error_d     = (width_q >= period_q) || (period_q == '0);
    rise_inc    = tod_add(next_rise_q, period_q);
    force_idle  = input_start_valid | input_period_valid | input_width_valid |
                  input_ts_tod_step | !enable | error_q;
    state_d     = state_q;
    next_rise_d = next_rise_q;
    next_fall_d = next_fall_q;
    pulse_d     = pulse_q;
    locked_d    = locked_q;
    if (force_idle) begin
      state_d  = IDLE;
      pulse_d  = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse_d  = 1'b0;
          locked_d = 1'b0;
          // error_d is the value error_q takes next, so a freshly loaded bad config never arms
          if (!error_d) begin
            next_rise_d = start_q;
            state_d     = CATCHUP;
          end
        end
        // Advance until the edge is now or in the future, so a past start never fires late
        CATCHUP: if (input_ts_tod > next_rise_q) next_rise_d = rise_inc;
                 else state_d = ARMED;
        ARMED: if (input_ts_tod >= next_rise_q) begin
          pulse_d     = 1'b1;
          next_fall_d = tod_add(next_rise_q, width_q);
          state_d     = HIGH;
        end
        HIGH: if (input_ts_tod >= next_fall_q) begin
          pulse_d  = 1'b0;
          locked_d = 1'b1;
          state_d  = ADD;
        end
        ADD: begin
          next_rise_d = rise_inc;
          state_d     = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= START_INIT;
      period_q    <= PERIOD_INIT;
      width_q     <= WIDTH_INIT;
      next_rise_q <= '0;
      next_fall_q <= '0;
      pulse_q     <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      period_q    <= period_d;
      width_q     <= width_d;
      next_rise_q <= next_rise_d;
      next_fall_q <= next_fall_d;
      pulse_q     <= pulse_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end
  assign locked       = locked_q;
  assign error        = error_q;
  assign output_pulse = pulse_q;
endmodule

// File: tb/tb_ptp_perout_sched.sv
// tb_ptp_perout_sched: scoreboard bench checking pulse edges against hand-computed ToD times
module tb_ptp_perout_sched;
  logic clk = 1'b0, rst = 1'b1, run = 1'b1;
  logic [95:0] tod = '0, inc = '0, in_start = '0, in_period = '0, in_width = '0;
  logic step = 1'b0, enable = 1'b0, sv = 1'b0, pv = 1'b0, wv = 1'b0;
  logic locked, error, output_pulse;
  typedef struct {logic lvl; logic lk; logic [95:0] t;} ev_t;
  ev_t sb[$];
  int n_chk = 0, n_pass = 0;
  ptp_perout_sched dut (
    .clk(clk), .rst(rst), .input_ts_tod(tod), .input_ts_tod_step(step), .enable(enable),
    .input_start(in_start), .input_start_valid(sv), .input_period(in_period),
    .input_period_valid(pv), .input_width(in_width), .input_width_valid(wv),
    .locked(locked), .error(error), .output_pulse(output_pulse)
  );
  always #5 if (run) clk = ~clk;
  function automatic logic [95:0] mk(input int unsigned s, input int unsigned ns);
    return {16'h0, s, ns, 16'h0};
  endfunction
  function automatic logic [95:0] tadd(input logic [95:0] a, input logic [95:0] b);
    logic [63:0] t;
    t = 64'(a[95:48]) * 64'd1_000_000_000 + 64'(a[47:16]) +
        64'(b[95:48]) * 64'd1_000_000_000 + 64'(b[47:16]);
    return mk(32'(t / 64'd1_000_000_000), 32'(t % 64'd1_000_000_000));
  endfunction
  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction
  task automatic push(input logic lvl, input logic lk, input logic [95:0] t);
    ev_t e;
    e.lvl = lvl;
    e.lk = lk;
    e.t = t;
    sb.push_back(e);
  endtask
  task automatic cyc();
    @(negedge clk);
    tod = tadd(tod, inc);
  endtask
  task automatic drain(input string nm, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk({nm, "_drain"}, 128'(sb.size()), 128'd0);
    sb.delete();
  endtask
  initial begin
    ev_t e;
    @(negedge rst);
    forever begin
      @(output_pulse);
      #1;
      chk("edge_expected", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.lvl ? "rise" : "fall", {30'd0, output_pulse, locked, tod}, {30'd0, e.lvl, e.lk, e.t});
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pulse", 128'(output_pulse), 128'd0);
    chk("rst_locked", 128'(locked), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("idle_disabled", 128'(output_pulse), 128'd0);
    enable = 1'b1;
    push(1, 0, mk(0, 0));
    push(0, 1, mk(0, 1000));
    cyc();
    cyc();
    inc = mk(0, 8);
    drain("defaults_first", 200);
    chk("locked_after_first", 128'(locked), 128'd1);
    tod = mk(0, 999_999_200);
    push(1, 1, mk(1, 0));
    push(0, 1, mk(1, 1000));
    drain("defaults_second", 400);
    tod = '0;
    inc = '0;
    in_period = mk(0, 999_999_996);
    pv = 1'b1;
    push(1, 0, mk(0, 0));
    push(0, 1, mk(0, 1000));
    cyc();
    pv = 1'b0;
    cyc();
    cyc();
    inc = mk(0, 8);
    drain("ns_first", 200);
    tod = mk(0, 999_999_196);
    push(1, 1, mk(0, 999_999_996));
    push(0, 1, mk(1, 996));
    drain("ns_second", 300);
    tod = mk(1, 999_999_192);
    push(1, 1, mk(1, 999_999_992));
    push(0, 1, mk(2, 992));
    drain("ns_third", 300);
    tod = mk(100, 500_000_000);
    in_start = mk(10, 0);
    in_period = mk(1, 0);
    sv = 1'b1;
    pv = 1'b1;
    push(1, 0, mk(101, 0));
    push(0, 1, mk(101, 1000));
    cyc();
    sv = 1'b0;
    pv = 1'b0;
    repeat (150) cyc();
    chk("catchup_no_pulse", 128'(output_pulse), 128'd0);
    chk("catchup_unlocked", 128'(locked), 128'd0);
    tod = mk(100, 999_999_200);
    drain("catchup", 300);
    in_width = mk(2, 0);
    wv = 1'b1;
    cyc();
    wv = 1'b0;
    repeat (10) cyc();
    chk("error_set", 128'(error), 128'd1);
    chk("error_pulse_low", 128'(output_pulse), 128'd0);
    tod = mk(101, 999_998_400);
    in_width = mk(0, 1000);
    wv = 1'b1;
    push(1, 0, mk(102, 0));
    push(0, 1, mk(102, 1000));
    cyc();
    wv = 1'b0;
    cyc();
    cyc();
    chk("error_clear", 128'(error), 128'd0);
    drain("resume", 400);
    tod = mk(102, 999_999_200);
    push(1, 1, mk(103, 0));
    drain("pre_step", 200);
    tod = tadd(tod, mk(5, 300_000_000));
    step = 1'b1;
    push(0, 0, tod);
    cyc();
    step = 1'b0;
    chk("step_unlock", 128'(locked), 128'd0);
    repeat (150) cyc();
    tod = mk(108, 999_999_200);
    push(1, 0, mk(109, 0));
    push(0, 1, mk(109, 1000));
    drain("realign", 300);
    tod = mk(109, 999_999_200);
    push(1, 1, mk(110, 0));
    drain("pre_rst", 200);
    run = 1'b0;
    push(0, 0, tod);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pulse", 128'(output_pulse), 128'd0);
    chk("async_rst_locked", 128'(locked), 128'd0);
    #5 rst = 1'b0;
    run = 1'b1;
    repeat (150) cyc();
    tod = mk(110, 999_999_200);
    push(1, 0, mk(111, 0));
    drain("post_rst", 200);
    enable = 1'b0;
    chk("trunc_still_high", 128'(output_pulse), 128'd1);
    push(0, 0, tod);
    drain("trunc", 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
